mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store stage: turns an EX/MEM memory instruction into one data-bus transaction.
// The pipeline is stalled until the access completes. Non-memory instructions pass straight through.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_have_inst,
  input  logic [31:0]       ex_pc,
  input  logic              ex_we,
  input  logic [4:0]        ex_wr,
  input  logic [31:0]       ex_alu_res,
  input  logic [31:0]       ex_sdata,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  output logic              dbus_req,
  output logic              dbus_wr,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_wstrb,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [31:0]       dbus_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  output logic [4:0]        mem_wr,
  output logic [31:0]       mem_pc,
  output logic              mem_have_inst,
  output logic              mem_excp,
  output logic              mem_stop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic              req_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;

  logic [1:0]  off_s;
  logic        aligned_s;
  logic        mem_acc_s;
  logic        op_s;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b100:  res = {24'd0, sh[7:0]};
      3'b101:  res = {16'd0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Alignment check and lane placement of store data/strobes
  always_comb begin
    off_s     = ex_alu_res[1:0];
    aligned_s = 1'b0;
    wstrb_d   = 4'b0000;
    wdata_d   = ex_sdata;
    case (ex_funct3[1:0])
      2'b00: begin
        aligned_s = 1'b1;
        wstrb_d   = 4'b0001 << off_s;
        wdata_d   = {4{ex_sdata[7:0]}};
      end
      2'b01: begin
        aligned_s = ~off_s[0];
        wstrb_d   = 4'b0011 << off_s;
        wdata_d   = {2{ex_sdata[15:0]}};
      end
      default: begin
        aligned_s = (off_s == 2'b00);
        wstrb_d   = 4'b1111;
        wdata_d   = ex_sdata;
      end
    endcase
    if (!ex_is_store) begin
      wstrb_d = 4'b0000;
    end else begin
      wstrb_d = wstrb_d;
    end
    mem_acc_s = ex_have_inst & (ex_is_load | ex_is_store);
    op_s      = mem_acc_s & aligned_s;
  end

  // Writeback, trace and stall outputs toward MEM/WB
  always_comb begin
    mem_pc        = ex_pc;
    mem_wr        = ex_wr;
    mem_have_inst = ex_have_inst;
    mem_excp      = mem_acc_s & ~aligned_s;
    mem_stop      = op_s & (state_q != S_DONE);
    mem_we        = 1'b0;
    mem_wd        = ex_alu_res;
    if (!ex_have_inst) begin
      mem_we = 1'b0;
    end else if (mem_acc_s) begin
      if (op_s && ex_is_load && !ex_is_store && (state_q == S_DONE)) begin
        mem_we = ex_we;
      end else begin
        mem_we = 1'b0;
      end
    end else begin
      mem_we = ex_we;
    end
    if (mem_acc_s && ex_is_load && !ex_is_store) begin
      mem_wd = load_extract(rdata_q, off_q, funct3_q);
    end else begin
      mem_wd = ex_alu_res;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_wr    = wr_q;
  assign dbus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dbus_wstrb = wstrb_q;
  assign dbus_wdata = wdata_q;

  // Access FSM; request fields are latched on leaving IDLE so they stay fixed until grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wstrb_q  <= 4'b0000;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      off_q    <= 2'b00;
      funct3_q <= 3'b000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_s) begin
            state_q  <= S_REQ;
            req_q    <= 1'b1;
            wr_q     <= ex_is_store;
            addr_q   <= ex_alu_res[ADDR_W-1:0];
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            off_q    <= off_s;
            funct3_q <= ex_funct3;
          end
        end
        S_REQ: begin
          if (dbus_gnt) begin
            req_q   <= 1'b0;
            state_q <= wr_q ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dbus_rvalid) begin
            rdata_q <= dbus_rdata;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit: each instruction is scheduled with chosen
// grant/read-data delays and a per-cycle expectation is derived from the transaction timing rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_have_inst;
  logic [31:0] ex_pc;
  logic        ex_we;
  logic [4:0]  ex_wr;
  logic [31:0] ex_alu_res;
  logic [31:0] ex_sdata;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic        dbus_req;
  logic        dbus_wr;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [4:0]  mem_wr;
  logic [31:0] mem_pc;
  logic        mem_have_inst;
  logic        mem_excp;
  logic        mem_stop;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_have_inst(ex_have_inst), .ex_pc(ex_pc), .ex_we(ex_we), .ex_wr(ex_wr),
    .ex_alu_res(ex_alu_res), .ex_sdata(ex_sdata), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .dbus_req(dbus_req), .dbus_wr(dbus_wr), .dbus_addr(dbus_addr),
    .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .mem_we(mem_we), .mem_wd(mem_wd), .mem_wr(mem_wr), .mem_pc(mem_pc),
    .mem_have_inst(mem_have_inst), .mem_excp(mem_excp), .mem_stop(mem_stop)
  );

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_stop, exp_req, exp_excp, exp_we, exp_wd_chk, exp_is_st;
  logic [31:0] exp_wd, exp_addr, exp_wdata;
  logic [3:0]  exp_strb;

  int          obs_stop_cnt, obs_req_cnt;
  logic        obs_excp, obs_we_last;
  logic [31:0] obs_wd_last, obs_addr, obs_wdata;
  logic [3:0]  obs_strb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Load result: pick the addressed bytes, then sign- or zero-extend
  function automatic logic [31:0] ld_model(input logic [31:0] w, input int off, input logic [2:0] f3);
    int size;
    logic [31:0] mask, val;
    size = size_of(f3);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    val  = (w >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
    return val;
  endfunction

  // Per-cycle comparison of the DUT against the expectations set by the driver
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_stop", {31'd0, mem_stop}, {31'd0, exp_stop});
      chk("dbus_req", {31'd0, dbus_req}, {31'd0, exp_req});
      chk("mem_excp", {31'd0, mem_excp}, {31'd0, exp_excp});
      chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      chk("mem_pc", mem_pc, ex_pc);
      chk("mem_wr", {27'd0, mem_wr}, {27'd0, ex_wr});
      chk("mem_have_inst", {31'd0, mem_have_inst}, {31'd0, ex_have_inst});
      if (exp_wd_chk) chk("mem_wd", mem_wd, exp_wd);
      if (exp_req) begin
        chk("dbus_addr", dbus_addr, exp_addr);
        chk("dbus_wr", {31'd0, dbus_wr}, {31'd0, exp_is_st});
        if (exp_is_st) begin
          chk("dbus_wstrb", {28'd0, dbus_wstrb}, {28'd0, exp_strb});
          chk("dbus_wdata", dbus_wdata, exp_wdata);
        end
      end
    end
  end

  // Present one instruction; g = cycles without grant, r = cycles in WAIT without rvalid
  task automatic run_inst(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic we,
                          input logic [4:0] wr, input int g, input int r, input logic [31:0] rd);
    int size, off, len;
    logic is_mem, aligned, op;
    size    = size_of(f3);
    off     = int'(addr[1:0]);
    aligned = ((off % size) == 0);
    is_mem  = v && (ld || st);
    op      = is_mem && aligned;
    len     = !op ? 1 : (st ? 3 + g : 4 + g + r);

    ex_have_inst = v;  ex_is_load = ld;  ex_is_store = st;  ex_funct3 = f3;
    ex_alu_res = addr; ex_sdata = sd;   ex_we = we;        ex_wr = wr;
    ex_pc = $urandom;

    exp_excp  = is_mem && !aligned;
    exp_addr  = {addr[31:2], 2'b00};
    exp_is_st = st;
    for (int i = 0; i < 4; i++) begin
      exp_strb[i] = (i >= off) && (i < off + size);
      exp_wdata[8*i +: 8] = sd[8*(i % size) +: 8];
    end
    obs_stop_cnt = 0; obs_req_cnt = 0; obs_excp = 1'b0;
    chk_en = 1'b1;

    for (int k = 0; k < len; k++) begin
      if (op && k >= 1 && k <= 1 + g) dbus_gnt = (k == 1 + g);
      else                             dbus_gnt = 1'($urandom_range(0, 1));
      if (op && ld && k >= 2 + g && k < len - 1) begin
        dbus_rvalid = (k == len - 2);
        dbus_rdata  = (k == len - 2) ? rd : $urandom;
      end else begin
        dbus_rvalid = 1'($urandom_range(0, 1));
        dbus_rdata  = $urandom;
      end
      exp_stop = op && (k < len - 1);
      exp_req  = op && (k >= 1) && (k <= 1 + g);
      if (!v)          exp_we = 1'b0;
      else if (is_mem) exp_we = (op && ld && k == len - 1) ? we : 1'b0;
      else             exp_we = we;
      exp_wd_chk = v && (!is_mem || (op && ld && k == len - 1));
      exp_wd     = is_mem ? ld_model(rd, off, f3) : addr;

      @(negedge clk);
      if (mem_stop) obs_stop_cnt++;
      if (dbus_req) begin
        obs_req_cnt++;
        obs_addr = dbus_addr; obs_strb = dbus_wstrb; obs_wdata = dbus_wdata;
      end
      if (k == 0) obs_excp = mem_excp;
      if (k == len - 1) begin
        obs_wd_last = mem_wd; obs_we_last = mem_we;
      end
      @(posedge clk); #1;
    end
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
  endtask

  logic [2:0] ld_f3_tab [5];

  initial begin
    logic v, ld, st;
    logic [2:0] f3;
    logic [31:0] addr;
    int kind, size;

    ld_f3_tab[0] = 3'b000; ld_f3_tab[1] = 3'b001; ld_f3_tab[2] = 3'b010;
    ld_f3_tab[3] = 3'b100; ld_f3_tab[4] = 3'b101;

    rst = 1'b1; ex_have_inst = 1'b0; ex_pc = 32'd0; ex_we = 1'b0; ex_wr = 5'd0;
    ex_alu_res = 32'd0; ex_sdata = 32'd0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'b000; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stop", {31'd0, mem_stop}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_excp", {31'd0, mem_excp}, 32'd0);
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {31'd0, dbus_req}, 32'd0);
    chk("post_rst_stop", {31'd0, mem_stop}, 32'd0);
    @(posedge clk); #1;

    // ALU pass-through
    run_inst(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 1'b1, 5'd5, 0, 0, 32'd0);
    chk("alu_wd", obs_wd_last, 32'h0000_1234);
    chk("alu_we", {31'd0, obs_we_last}, 32'd1);
    chk("alu_stall", obs_stop_cnt, 32'd0);

    // LB at 0x103
    run_inst(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 1'b1, 5'd7, 0, 0, 32'h80FF_0000);
    chk("lb_stall", obs_stop_cnt, 32'd3);
    chk("lb_wd", obs_wd_last, 32'hFFFF_FF80);
    chk("lb_we", {31'd0, obs_we_last}, 32'd1);

    // SH at 0x102 with grant delayed two cycles
    run_inst(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hAAAA_BEEF, 1'b1, 5'd3, 2, 0, 32'd0);
    chk("sh_strb", {28'd0, obs_strb}, 32'h0000_000C);
    chk("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", obs_addr, 32'h0000_0100);
    chk("sh_stall", obs_stop_cnt, 32'd4);
    chk("sh_req_cycles", obs_req_cnt, 32'd3);
    chk("sh_we", {31'd0, obs_we_last}, 32'd0);

    // Misaligned LW
    run_inst(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0, 1'b1, 5'd9, 0, 0, 32'd0);
    chk("lw_mis_excp", {31'd0, obs_excp}, 32'd1);
    chk("lw_mis_req", obs_req_cnt, 32'd0);
    chk("lw_mis_stall", obs_stop_cnt, 32'd0);
    chk("lw_mis_we", {31'd0, obs_we_last}, 32'd0);

    // LHU at 0x2, reset while waiting for read data, late rvalid afterwards
    chk_en = 1'b0;
    ex_have_inst = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b101;
    ex_alu_res = 32'h0000_0002; ex_we = 1'b1; ex_wr = 5'd4;
    @(posedge clk); #1;
    dbus_gnt = 1'b1;
    @(posedge clk); #1;
    dbus_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("wait_stop", {31'd0, mem_stop}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; ex_have_inst = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("abort_stop", {31'd0, mem_stop}, 32'd0);
    chk("abort_req", {31'd0, dbus_req}, 32'd0);
    chk("abort_we", {31'd0, mem_we}, 32'd0);
    chk("abort_excp", {31'd0, mem_excp}, 32'd0);
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    run_inst(1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'd0, 1'b1, 5'd4, 1, 1, 32'h8765_4321);
    chk("lhu_after_rst_wd", obs_wd_last, 32'h0000_8765);
    chk("lhu_after_rst_stall", obs_stop_cnt, 32'd5);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      v    = ($urandom_range(0, 9) != 0);
      if (kind < 3) begin
        ld = 1'b0; st = 1'b0; f3 = 3'($urandom_range(0, 7));
      end else if (kind < 7) begin
        ld = 1'b1; st = 1'b0; f3 = ld_f3_tab[$urandom_range(0, 4)];
      end else begin
        ld = 1'b0; st = 1'b1; f3 = 3'($urandom_range(0, 2));
      end
      addr = $urandom;
      size = size_of(f3);
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(size) - 32'd1);
      run_inst(v, ld, st, f3, addr, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
